// File: rtl/buzzer_sequencer.sv
// Background-music / jingle sequencer: owns the music-select state and beat index.
// Optional macro BUZZER_PAUSE_EN adds a pause input that freezes the game song.
module buzzer_sequencer #(
   parameter int BEAT_DIV = 12500000,
   parameter int GAME_LEN = 128,
   parameter int WIN_LEN  = 32,
   parameter int LOSE_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       win,
   input  logic       lose,
`ifdef BUZZER_PAUSE_EN
   input  logic       pause,
`endif
   output logic [1:0] state,
   output logic [7:0] beat,
   output logic       beat_tick,
   output logic       song_done,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_GAME = 2'b01,
      S_WIN  = 2'b10,
      S_LOSE = 2'b11
   } state_e;

   localparam logic [23:0] PRESC_LAST = 24'(BEAT_DIV - 1);
   localparam logic [7:0]  GAME_LAST  = 8'(GAME_LEN - 1);
   localparam logic [7:0]  WIN_LAST   = 8'(WIN_LEN - 1);
   localparam logic [7:0]  LOSE_LAST  = 8'(LOSE_LEN - 1);

   state_e      state_q;
   logic [7:0]  beat_q;
   logic [23:0] presc_q;
   logic        done_q;
   logic        hold;
   logic        tick;
   logic [7:0]  jingle_last;

`ifdef BUZZER_PAUSE_EN
   assign hold = (state_q == S_GAME) && pause;
`else
   assign hold = 1'b0;
`endif

   assign tick        = (state_q != S_IDLE) && !hold && (presc_q == PRESC_LAST);
   assign jingle_last = (state_q == S_WIN) ? WIN_LAST : LOSE_LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= 8'd0;
         presc_q <= 24'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               presc_q <= 24'd0;
               beat_q  <= 8'd0;
               if (start) state_q <= S_GAME;
            end
            S_GAME: begin
               // Game events override any beat advance on the same edge.
               if (lose) begin
                  state_q <= S_LOSE;
                  presc_q <= 24'd0;
                  beat_q  <= 8'd0;
               end else if (win) begin
                  state_q <= S_WIN;
                  presc_q <= 24'd0;
                  beat_q  <= 8'd0;
               end else if (!hold) begin
                  presc_q <= tick ? 24'd0 : presc_q + 24'd1;
                  if (tick) beat_q <= (beat_q == GAME_LAST) ? 8'd0 : beat_q + 8'd1;
               end
            end
            default: begin
               if (tick && (beat_q == jingle_last)) begin
                  state_q <= S_IDLE;
                  presc_q <= 24'd0;
                  beat_q  <= 8'd0;
                  done_q  <= 1'b1;
               end else begin
                  presc_q <= tick ? 24'd0 : presc_q + 24'd1;
                  if (tick) beat_q <= beat_q + 8'd1;
               end
            end
         endcase
      end
   end

   assign state     = state_q;
   assign beat      = beat_q;
   assign beat_tick = tick;
   assign song_done = done_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: directed scenarios plus random events against an
// elapsed-time model of the songs (pause scenario only when BUZZER_PAUSE_EN is set).
module tb_buzzer_sequencer;
   localparam int DIV   = 4;
   localparam int GLEN  = 8;
   localparam int WLEN  = 4;
   localparam int LLEN  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       win = 1'b0;
   logic       lose = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] state;
   logic [7:0] beat;
   logic       beat_tick;
   logic       song_done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Model: song mode plus cycles elapsed (excluding paused cycles) since entering it.
   int m_mode = 0;
   int m_el   = 0;
   bit m_done = 1'b0;

   buzzer_sequencer #(
      .BEAT_DIV(DIV), .GAME_LEN(GLEN), .WIN_LEN(WLEN), .LOSE_LEN(LLEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .win(win),
      .lose(lose),
`ifdef BUZZER_PAUSE_EN
      .pause(pause),
`endif
      .state(state),
      .beat(beat),
      .beat_tick(beat_tick),
      .song_done(song_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int len_of(int mode);
      case (mode)
         1: return GLEN;
         2: return WLEN;
         default: return LLEN;
      endcase
   endfunction

   function automatic bit paused_now();
`ifdef BUZZER_PAUSE_EN
      return (m_mode == 1) && pause;
`else
      return 1'b0 && pause;
`endif
   endfunction

   function automatic logic [12:0] expv();
      logic [1:0] s;
      logic [7:0] b;
      logic       t;
      s = 2'(m_mode);
      b = (m_mode == 0) ? 8'd0 : 8'((m_el / DIV) % len_of(m_mode));
      t = (m_mode != 0) && !paused_now() && ((m_el % DIV) == DIV - 1);
      return {s, b, t, m_done, (m_mode != 0)};
   endfunction

   function automatic logic [12:0] obsv();
      return {state, beat, beat_tick, song_done, busy};
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_el   = 0;
      m_done = 1'b0;
   endtask

   // One clock edge: advance the model with the inputs sampled at that edge.
   task automatic step();
      @(posedge clk);
      m_done = 1'b0;
      case (m_mode)
         0: if (start) begin m_mode = 1; m_el = 0; end
         1: begin
            if (lose) begin m_mode = 3; m_el = 0; end
            else if (win) begin m_mode = 2; m_el = 0; end
            else if (!paused_now()) m_el++;
         end
         default: begin
            if (m_el == len_of(m_mode) * DIV - 1) begin
               m_mode = 0; m_el = 0; m_done = 1'b1;
            end else m_el++;
         end
      endcase
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if (obsv() !== 13'd0) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", obsv(), 13'd0);
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_game_loop();
      int ticks;
      start = 1'b1; step(); start = 1'b0;
      checks++;
      if ({state, beat} !== {2'b01, 8'd0}) begin
         errors++;
         $display("FAIL game_entry got=%b/%0d want=01/0", state, beat);
      end
      ticks = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (beat_tick === 1'b1) ticks++;
         checks++;
         if (obsv() !== expv()) begin
            errors++;
            $display("FAIL game_loop cyc=%0d got=%h want=%h", i, obsv(), expv());
         end
      end
      checks++;
      if (ticks !== 8 || beat !== 8'd0 || state !== 2'b01) begin
         errors++;
         $display("FAIL game_wrap ticks=%0d beat=%0d state=%b want 8/0/01", ticks, beat, state);
      end
   endtask

   task automatic test_win();
      int n = 0;
      while (m_el / DIV % GLEN != 5 && n < 64) begin step(); n++; end
      checks++;
      if (beat !== 8'd5) begin
         errors++;
         $display("FAIL win_reach_beat5 got=%0d want=5", beat);
      end
      win = 1'b1; step(); win = 1'b0;
      checks++;
      if ({state, beat} !== {2'b10, 8'd0}) begin
         errors++;
         $display("FAIL win_entry got=%b/%0d want=10/0", state, beat);
      end
      for (int i = 0; i < 15; i++) begin
         step();
         checks++;
         if (obsv() !== expv() || state !== 2'b10) begin
            errors++;
            $display("FAIL win_play cyc=%0d got=%h want=%h", i, obsv(), expv());
         end
      end
      step();
      checks++;
      if ({state, song_done, busy} !== {2'b00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL win_done got=%b/%b/%b want=00/1/0", state, song_done, busy);
      end
      step();
      checks++;
      if (song_done !== 1'b0) begin
         errors++;
         $display("FAIL win_done_pulse got=%b want=0", song_done);
      end
   endtask

   task automatic test_both();
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      win = 1'b1; lose = 1'b1; step(); win = 1'b0; lose = 1'b0;
      checks++;
      if ({state, beat} !== {2'b11, 8'd0}) begin
         errors++;
         $display("FAIL both_lose_priority got=%b/%0d want=11/0", state, beat);
      end
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (obsv() !== expv()) begin
            errors++;
            $display("FAIL lose_play cyc=%0d got=%h want=%h", i, obsv(), expv());
         end
      end
      checks++;
      if ({state, song_done} !== {2'b00, 1'b1}) begin
         errors++;
         $display("FAIL lose_done got=%b/%b want=00/1", state, song_done);
      end
   endtask

   task automatic test_jingle_ignore();
      int n;
      start = 1'b1; step(); start = 1'b0;
      win = 1'b1; step(); win = 1'b0;
      n = 0;
      while (beat !== 8'd2 && n < 20) begin step(); n++; end
      lose = 1'b1; start = 1'b1; step(); lose = 1'b0; start = 1'b0;
      n += 1;
      checks++;
      if (state !== 2'b10 || obsv() !== expv()) begin
         errors++;
         $display("FAIL win_ignore got=%h want=%h", obsv(), expv());
      end
      while (state !== 2'b00 && n < 40) begin step(); n++; end
      checks++;
      if (n !== 16 || song_done !== 1'b1) begin
         errors++;
         $display("FAIL win_ignore_len got=%0d cycles done=%b want=16/1", n, song_done);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      start = 1'b1; step(); start = 1'b0;
      lose = 1'b1; step(); lose = 1'b0;
      n = 0;
      while (beat !== 8'd2 && n < 20) begin step(); n++; end
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({state, beat, song_done, busy} !== 12'd0) begin
         errors++;
         $display("FAIL async_reset got=%b/%0d/%b/%b want=00/0/0/0", state, beat, song_done, busy);
      end
      #2 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obsv() !== expv()) begin
            errors++;
            $display("FAIL after_reset cyc=%0d got=%h want=%h", i, obsv(), expv());
         end
      end
   endtask

`ifdef BUZZER_PAUSE_EN
   task automatic test_pause();
      int n = 0;
      start = 1'b1; step(); start = 1'b0;
      while (!(m_el == 13) && n < 40) begin step(); n++; end
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (beat !== 8'd3 || beat_tick !== 1'b0 || state !== 2'b01) begin
            errors++;
            $display("FAIL pause_hold cyc=%0d beat=%0d tick=%b state=%b want 3/0/01", i, beat, beat_tick, state);
         end
      end
      pause = 1'b0;
      step(); step(); step();
      checks++;
      if (beat !== 8'd4 || obsv() !== expv()) begin
         errors++;
         $display("FAIL pause_resume got=%h want=%h", obsv(), expv());
      end
      pause = 1'b1; win = 1'b1; step(); win = 1'b0; pause = 1'b0;
      checks++;
      if ({state, beat} !== {2'b10, 8'd0}) begin
         errors++;
         $display("FAIL pause_event got=%b/%0d want=10/0", state, beat);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 7) == 0);
         win   = ($urandom_range(0, 19) == 0);
         lose  = ($urandom_range(0, 23) == 0);
`ifdef BUZZER_PAUSE_EN
         pause = ($urandom_range(0, 3) == 0);
`endif
         step();
         checks++;
         if (obsv() !== expv()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h want=%h", i, obsv(), expv());
         end
      end
      start = 1'b0; win = 1'b0; lose = 1'b0; pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_game_loop();
      test_win();
      test_both();
      test_jingle_ignore();
      test_reset_mid();
`ifdef BUZZER_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Sequences background music and jingles for the speaker path.
- Owns the 2-bit music state that selects the game, win or lose note-divider set in the buzzer selector.
- Generates the beat index that the per-song note tables use.
- Reacts to game events: start, win and lose. Plays the win or lose jingle exactly once, then falls silent (IDLE).

Parameters:
- BEAT_DIV, 12500000, clk cycles per beat (1/8 s at 100 MHz); range 2..2^24.
- GAME_LEN, 128, beats in the looping game song; range 1..256.
- WIN_LEN, 32, beats in the one-shot win jingle; range 1..256.
- LOSE_LEN, 32, beats in the one-shot lose jingle; range 1..256.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each clk; begins game music from IDLE.
- win  in  1  level, sampled each clk; game won.
- lose  in  1  level, sampled each clk; game lost.
- state  out  2  music select: 00 IDLE/silent, 01 GAME, 10 WIN, 11 LOSE; registered.
- beat  out  8  current beat index within the active song; registered.
- beat_tick  out  1  one-cycle strobe on the cycle the beat advances; combinational from registers.
- song_done  out  1  one-cycle pulse when a jingle finishes; registered.
- busy  out  1  high when state != 00.

Behaviour:
- Reset (async, rst=1): state=00, beat=0, prescaler=0, song_done=0. beat_tick=0 and busy=0 follow from this.
- Reset mid-song: abandons the song immediately. No song_done pulse.
- Prescaler: 24-bit counter.
  - Held at 0 in IDLE.
  - Otherwise counts 0..BEAT_DIV-1 and wraps to 0.
  - Cleared to 0 on every state change.
- beat_tick = (state!=00) && (prescaler==BEAT_DIV-1). The first tick occurs BEAT_DIV cycles after entering a state.
- beat updates on the clk edge where beat_tick=1. It is cleared to 0 on every state change.
- FSM transitions, evaluated each clk edge:
  - IDLE: start=1 -> GAME next cycle. win and lose are ignored in IDLE.
  - GAME, win or lose asserted: lose=1 -> LOSE; else win=1 -> WIN.
    - If both are high, LOSE takes priority.
    - Events take priority over a simultaneous beat_tick: the state changes and beat=0.
  - GAME, tick with no event: beat==GAME_LEN-1 -> beat=0 (loop); else beat+1.
  - GAME: start is ignored.
  - WIN or LOSE, tick: if beat==LEN-1 (WIN_LEN or LOSE_LEN), then state=00, beat=0 and song_done=1 for exactly that first IDLE cycle. Else beat+1.
  - WIN or LOSE: start, win and lose are all ignored until IDLE is reached.
- song_done: high only for the single cycle after a jingle's final beat ends. 0 at all other times.
- Latency: an input event at edge n produces its new state at edge n (visible from cycle n+1). No other pipeline delay.
- Beat width: 8 bits; beat never exceeds LEN-1.

Optional Feature:
- Macro: BUZZER_PAUSE_EN.
- Defined: adds input port pause (1 bit, level).
  - In GAME, pause=1 freezes the prescaler and beat, and forces beat_tick=0.
  - state stays 01 while paused.
  - win and lose still act while paused (event wins, beat=0).
  - pause is ignored in IDLE, WIN and LOSE.
- Undefined: no pause port. Behaviour is exactly as above.

Test Plan (BEAT_DIV=4, GAME_LEN=8, WIN_LEN=4, LOSE_LEN=4):
- Reset then start=1 for 1 cycle -> state=01 next cycle, beat=0. beat_tick every 4 cycles. beat runs 0..7, then wraps to 0 after 32 cycles.
- GAME at beat=5, win=1 for 1 cycle -> state=10, beat=0. After 16 cycles: state=00, song_done high for 1 cycle, busy=0.
- GAME, win=1 and lose=1 together -> state=11. After 16 cycles: IDLE with song_done pulse.
- In WIN at beat=2, pulse lose and start -> no change. Jingle completes normally at 16 cycles from entry.
- rst asserted asynchronously mid-LOSE at beat=2 -> state=00 and beat=0 immediately. song_done stays 0.
- BUZZER_PAUSE_EN: pause=1 for 10 cycles in GAME at beat=3 -> beat holds 3, no tick. Resumes with the original prescaler phase after release.
